// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package div_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Smallest r with 2**r >= value; sizes the iteration counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Request/response bundle between the pipeline controller and iter_divider.
interface iter_divider_if #(parameter int Width = 32);

  logic             start_i;
  logic             signed_i;
  logic [Width-1:0] dividend_i;
  logic [Width-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [Width-1:0] quotient_o;
  logic [Width-1:0] remainder_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] rem,
  input  logic [Width-1:0] quo,
  input  logic [Width-1:0] divisor_mag,
  output logic [Width-1:0] next_rem,
  output logic [Width-1:0] next_quo
);

  logic             carry_s;
  logic [Width-1:0] shifted_s;
  logic [Width:0]   trial_s;
  logic             fits_s;

  assign carry_s   = rem[Width-1];
  assign shifted_s = {rem[Width-2:0], quo[Width-1]};
  assign trial_s   = {1'b0, shifted_s} - {1'b0, divisor_mag};
  // The bit shifted out of rem is weight 2**Width, so it always covers the divisor.
  assign fits_s    = carry_s | ~trial_s[Width];

  // Keep the trial difference or restore the shifted remainder.
  always_comb begin
    next_rem = shifted_s;
    next_quo = {quo[Width-2:0], 1'b0};
    if (fits_s) begin
      next_rem = trial_s[Width-1:0];
      next_quo = {quo[Width-2:0], 1'b1};
    end else begin
      next_rem = shifted_s;
      next_quo = {quo[Width-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per cycle, quotient to LO, remainder to HI.
// Optional build macro DIV_FAST_ZERO_EN short-circuits divide-by-zero to a one-cycle op.
module iter_divider
  import div_pkg::*;
#(
  parameter int Width = DivWidth
) (
  input  logic         clk_i,
  input  logic         rst_i,
  iter_divider_if.slave div_if
);

  localparam int              CntW      = clog2(Width);
  localparam logic [CntW-1:0] LastCount = CntW'(Width - 1);

  div_state_e       state_r;
  div_state_e       state_next_s;
  logic [CntW-1:0]  count_r;
  logic [Width-1:0] rem_r;
  logic [Width-1:0] quo_r;
  logic [Width-1:0] dvsr_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [Width-1:0] quotient_r;
  logic [Width-1:0] remainder_r;

  logic [Width-1:0] step_rem_s;
  logic [Width-1:0] step_quo_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [Width-1:0] dvd_mag_s;
  logic [Width-1:0] dvs_mag_s;
  logic             dvs_zero_s;
  logic             fast_zero_s;
  logic             busy_s;
  logic             done_s;

  div_step #(.Width(Width)) u_step (
    .rem         (rem_r),
    .quo         (quo_r),
    .divisor_mag (dvsr_r),
    .next_rem    (step_rem_s),
    .next_quo    (step_quo_s)
  );

  // Operand magnitudes and sign flags for the incoming request.
  always_comb begin
    dvd_neg_s  = div_if.signed_i & div_if.dividend_i[Width-1];
    dvs_neg_s  = div_if.signed_i & div_if.divisor_i[Width-1];
    dvd_mag_s  = dvd_neg_s ? ({Width{1'b0}} - div_if.dividend_i) : div_if.dividend_i;
    dvs_mag_s  = dvs_neg_s ? ({Width{1'b0}} - div_if.divisor_i) : div_if.divisor_i;
    dvs_zero_s = (div_if.divisor_i == {Width{1'b0}});
`ifdef DIV_FAST_ZERO_EN
    fast_zero_s = dvs_zero_s;
`else
    fast_zero_s = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (div_if.start_i) begin
          state_next_s = fast_zero_s ? DONE : BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (count_r == LastCount) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      BUSY: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand latch, iteration datapath and sign-corrected result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r     <= {CntW{1'b0}};
      rem_r       <= {Width{1'b0}};
      quo_r       <= {Width{1'b0}};
      dvsr_r      <= {Width{1'b0}};
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient_r  <= {Width{1'b0}};
      remainder_r <= {Width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (div_if.start_i) begin
            dvsr_r  <= dvs_mag_s;
            rem_r   <= {Width{1'b0}};
            quo_r   <= dvd_mag_s;
            count_r <= {CntW{1'b0}};
            // A zero divisor leaves the all-ones quotient unnegated.
            q_neg_r <= (dvd_neg_s ^ dvs_neg_s) & ~dvs_zero_s;
            r_neg_r <= dvd_neg_s;
            if (fast_zero_s) begin
              quotient_r  <= {Width{1'b1}};
              remainder_r <= div_if.dividend_i;
            end
          end
        end
        BUSY: begin
          rem_r   <= step_rem_s;
          quo_r   <= step_quo_s;
          count_r <= count_r + CntW'(1);
          if (count_r == LastCount) begin
            quotient_r  <= q_neg_r ? ({Width{1'b0}} - step_quo_s) : step_quo_s;
            remainder_r <= r_neg_r ? ({Width{1'b0}} - step_rem_s) : step_rem_s;
          end
        end
        DONE: begin
          count_r <= {CntW{1'b0}};
        end
        default: begin
          count_r <= {CntW{1'b0}};
        end
      endcase
    end
  end

  assign div_if.busy_o      = busy_s;
  assign div_if.done_o      = done_s;
  assign div_if.quotient_o  = quotient_r;
  assign div_if.remainder_o = remainder_r;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed table, corner sequences, random vs. arithmetic model.
module tb_iter_divider;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  iter_divider_if #(.Width(W)) dif ();

  iter_divider #(.Width(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_if (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: truncating division from plain arithmetic, zero divisor handled explicitly.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'd0) return 1;
`endif
    return W + 1;
  endfunction

  // Starting at a negedge, sample until done_o is seen; cycles = done cycle index (1-based), -1 on timeout.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = -1;
    busy_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (dif.busy_o === 1'b1) busy_cnt++;
      if (dif.done_o === 1'b1) begin
        cycles = k + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input string tag);
    int lat;
    int bc;
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.signed_i   = sgn;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    @(negedge clk);
    dif.start_i = 1'b0;
    wait_done(lat, bc);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(b)));
    check({tag, " busy_cycles"}, 64'(bc), 64'(exp_lat(b)));
    check({tag, " quotient"}, 64'(dif.quotient_o), 64'(eq));
    check({tag, " remainder"}, 64'(dif.remainder_o), 64'(er));
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_pulse_width"}, 64'({dif.done_o, dif.busy_o}), 64'(0));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rq;
    logic [31:0] rr;
    logic        rs;
    int          lat;
    int          bc;
    int          done_seen;

    n_vec = 0;
    n_err = 0;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    tbl[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    tbl[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    tbl[6]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    tbl[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    tbl[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    tbl[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    tbl[10] = '{1'b0, 32'd0,          32'd3,          32'd0,          32'd0};
    tbl[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};

    rst            = 1'b1;
    dif.start_i    = 1'b0;
    dif.signed_i   = 1'b0;
    dif.dividend_i = 32'd0;
    dif.divisor_i  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(dif.busy_o), 64'(0));
    check("reset done", 64'(dif.done_o), 64'(0));
    check("reset quotient", 64'(dif.quotient_o), 64'(0));
    check("reset remainder", 64'(dif.remainder_o), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp_q, tbl[i].exp_r, $sformatf("tbl%0d", i));
    end

    // start held high with changing operands: only the first request counts
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.signed_i   = 1'b0;
    dif.dividend_i = 32'd1000;
    dif.divisor_i  = 32'd7;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (dif.done_o === 1'b1) break;
      dif.dividend_i = $urandom;
      dif.divisor_i  = $urandom_range(1, 50);
      dif.signed_i   = 1'(($urandom & 32'd1));
    end
    dif.start_i = 1'b0;
    check("held_start done", 64'(dif.done_o), 64'(1));
    check("held_start quotient", 64'(dif.quotient_o), 64'(142));
    check("held_start remainder", 64'(dif.remainder_o), 64'(6));
    repeat (4) @(negedge clk);
    check("hold busy", 64'(dif.busy_o), 64'(0));
    check("hold quotient", 64'(dif.quotient_o), 64'(142));
    check("hold remainder", 64'(dif.remainder_o), 64'(6));
    dif.start_i    = 1'b1;
    dif.signed_i   = 1'b0;
    dif.dividend_i = 32'd50;
    dif.divisor_i  = 32'd5;
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (5) @(negedge clk);
    check("new_start busy", 64'(dif.busy_o), 64'(1));
    check("new_start keeps quotient", 64'(dif.quotient_o), 64'(142));
    check("new_start keeps remainder", 64'(dif.remainder_o), 64'(6));
    wait_done(lat, bc);
    check("second op seen", 64'(lat > 0), 64'(1));
    check("second op quotient", 64'(dif.quotient_o), 64'(10));
    check("second op remainder", 64'(dif.remainder_o), 64'(0));

    // reset in the middle of an iteration aborts without a done pulse
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.dividend_i = 32'd12345;
    dif.divisor_i  = 32'd67;
    @(negedge clk);
    dif.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(dif.busy_o), 64'(0));
    check("abort done", 64'(dif.done_o), 64'(0));
    check("abort quotient", 64'(dif.quotient_o), 64'(0));
    check("abort remainder", 64'(dif.remainder_o), 64'(0));
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dif.done_o === 1'b1) done_seen++;
    end
    check("abort no_done", 64'(done_seen), 64'(0));
    run_op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, "after_abort");

    // randomized operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rs = 1'(($urandom & 32'd1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      ref_div(rs, ra, rb, rq, rr);
      run_op(rs, ra, rb, rq, rr, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
